result_display_sequencer: RTL and testbench

- Downstream consumer of the regression datapath outputs: slope, intercept and determinant digit pairs, plus the result-done and error flags.
- Captures a result snapshot when the final multiply finishes.
- Pages between slope, intercept and determinant. Time-multiplexes the tens/ones digits onto one 7-segment bus with a sign LED.
- Shows error codes instead of values when input or determinant errors are flagged.

---
 rtl/result_display_pkg.sv | 45 ++++
 rtl/result_display_seg7_encode.sv | 28 ++
 rtl/result_display_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_result_display_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/result_display_pkg.sv
// rtl/result_display_pkg.sv - shared types, glyphs and error codes for the result display
// Purpose: page state encoding, result snapshot layout, 7-segment glyph constants,
//          error code digits and the state-to-page mapping used by the sequencer.
// Ports:   none (package).
package result_display_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_SLOPE     = 3'd1,
        ST_INTERCEPT = 3'd2,
        ST_DET       = 3'd3,
        ST_ERROR     = 3'd4
    } page_state_t;

    typedef struct packed {
        logic [3:0] slope_ten;
        logic [3:0] slope_one;
        logic [3:0] b_ten;
        logic [3:0] b_one;
        logic [3:0] det_ten;
        logic [3:0] det_one;
        logic       slope_neg;
        logic       b_neg;
        logic       det_neg;
    } snapshot_t;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_OVF   = 7'h5C;

    localparam logic [3:0] ERR_CODE_DET    = 4'd1;
    localparam logic [3:0] ERR_CODE_VALUES = 4'd2;

    // WAIT and ERROR both report page 0; only value pages are numbered.
    function automatic logic [1:0] page_code(input page_state_t s);
        case (s)
            ST_SLOPE:     page_code = 2'd1;
            ST_INTERCEPT: page_code = 2'd2;
            ST_DET:       page_code = 2'd3;
            default:      page_code = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/result_display_seg7_encode.sv
// rtl/result_display_seg7_encode.sv - 4-bit digit to active-high 7-segment glyph
// Purpose: combinational decimal glyph encoder; values 10-15 map to the overflow glyph.
// Ports:   digit [3:0] in  - digit value
//          glyph [6:0] out - segments, bit0 = a ... bit6 = g
module seg7_encode
    import result_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] glyph
);

    always_comb begin
        case (digit)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = SEG_OVF;
        endcase
    end

endmodule

// File: rtl/result_display_sequencer.sv
// rtl/result_display_sequencer.sv - pages regression results onto a muxed 2-digit 7-segment display
// Purpose: snapshots slope/intercept/determinant digits on result_valid, pages through them
//          on next_btn rising edges, shows E1/E2 while error flags are high, and
//          time-multiplexes tens/ones onto one segment bus with a sign LED.
// Config:  define RESULT_DISPLAY_AUTO_CYCLE_EN to also step pages every CYCLE_TICKS clocks.
// Ports:   clk, rst (async active-low); result_valid; slope/b/det digit pairs and signs;
//          error_det, error_values (levels); next_btn (level button);
//          seg [6:0], digit_sel [1:0] (10 = tens, 01 = ones), sign_led, page [1:0], err_active.
module result_display_sequencer
    import result_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
`ifdef RESULT_DISPLAY_AUTO_CYCLE_EN
    ,
    parameter int CYCLE_TICKS = 50000000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       result_valid,
    input  logic [3:0] slope_ten,
    input  logic [3:0] slope_one,
    input  logic [3:0] b_ten,
    input  logic [3:0] b_one,
    input  logic [3:0] det_ten,
    input  logic [3:0] det_one,
    input  logic       slope_neg,
    input  logic       b_neg,
    input  logic       det_neg,
    input  logic       error_det,
    input  logic       error_values,
    input  logic       next_btn,
    output logic [6:0] seg,
    output logic [1:0] digit_sel,
    output logic       sign_led,
    output logic [1:0] page,
    output logic       err_active
);

    localparam int RW = $clog2(REFRESH_DIV);

    page_state_t   state, state_n;
    snapshot_t     snap, snap_n;
    logic          has_snap;
    logic          btn_d;
    logic [RW-1:0] refresh_cnt, refresh_cnt_n;
    logic [1:0]    digit_sel_n;
    logic          advance, step, err_any;
    logic [3:0]    ten_n, one_n, digit_val;
    logic          neg_n, value_page_n;
    logic [6:0]    enc_glyph, glyph_n;
    logic          sign_n;

    assign advance = next_btn & ~btn_d;
    assign err_any = error_values | error_det;

`ifdef RESULT_DISPLAY_AUTO_CYCLE_EN
    localparam int CW = $clog2(CYCLE_TICKS);

    logic [CW-1:0] cycle_cnt;
    logic          in_value_page;
    logic          auto_tick;

    assign in_value_page = (state == ST_SLOPE) || (state == ST_INTERCEPT) || (state == ST_DET);
    assign auto_tick     = in_value_page && (cycle_cnt == CW'(CYCLE_TICKS - 1));
    assign step          = advance | auto_tick;

    // A manual advance restarts the dwell so the new page gets a full period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (!in_value_page || advance || auto_tick) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end
`else
    assign step = advance;
`endif

    always_comb begin
        snap_n = snap;
        if (result_valid) begin
            snap_n = '{slope_ten, slope_one, b_ten, b_one, det_ten, det_one,
                       slope_neg, b_neg, det_neg};
        end
    end

    // Errors take priority over everything, including a coincident result_valid.
    always_comb begin
        state_n = state;
        if (err_any) begin
            state_n = ST_ERROR;
        end else begin
            case (state)
                ST_WAIT:      if (result_valid) state_n = ST_SLOPE;
                ST_SLOPE:     if (step) state_n = ST_INTERCEPT;
                ST_INTERCEPT: if (step) state_n = ST_DET;
                ST_DET:       if (step) state_n = ST_SLOPE;
                ST_ERROR:     state_n = (has_snap || result_valid) ? ST_SLOPE : ST_WAIT;
                default:      state_n = ST_WAIT;
            endcase
        end
    end

    // Any page change restarts the mux on the tens digit.
    always_comb begin
        refresh_cnt_n = refresh_cnt + 1'b1;
        digit_sel_n   = digit_sel;
        if (state_n != state) begin
            refresh_cnt_n = '0;
            digit_sel_n   = 2'b10;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt_n = '0;
            digit_sel_n   = ~digit_sel;
        end
    end

    // Display values are derived from next-cycle state so seg, sign_led and
    // digit_sel all land in the same register stage.
    always_comb begin
        ten_n        = 4'd0;
        one_n        = 4'd0;
        neg_n        = 1'b0;
        value_page_n = 1'b1;
        case (state_n)
            ST_SLOPE:     begin ten_n = snap_n.slope_ten; one_n = snap_n.slope_one; neg_n = snap_n.slope_neg; end
            ST_INTERCEPT: begin ten_n = snap_n.b_ten;     one_n = snap_n.b_one;     neg_n = snap_n.b_neg;     end
            ST_DET:       begin ten_n = snap_n.det_ten;   one_n = snap_n.det_one;   neg_n = snap_n.det_neg;   end
            default:      value_page_n = 1'b0;
        endcase
    end

    always_comb begin
        if (state_n == ST_ERROR) begin
            digit_val = error_values ? ERR_CODE_VALUES : ERR_CODE_DET;
        end else begin
            digit_val = digit_sel_n[1] ? ten_n : one_n;
        end
    end

    seg7_encode u_encode (
        .digit (digit_val),
        .glyph (enc_glyph)
    );

    always_comb begin
        case (state_n)
            ST_WAIT:      glyph_n = SEG_DASH;
            ST_ERROR:     glyph_n = digit_sel_n[1] ? SEG_E : enc_glyph;
            ST_SLOPE,
            ST_INTERCEPT,
            ST_DET:       glyph_n = enc_glyph;
            default:      glyph_n = SEG_BLANK;
        endcase
    end

    // No "-0": a zero value never lights the sign.
    assign sign_n = value_page_n && neg_n && !((ten_n == 4'd0) && (one_n == 4'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_WAIT;
            snap        <= '0;
            has_snap    <= 1'b0;
            btn_d       <= 1'b0;
            refresh_cnt <= '0;
            digit_sel   <= 2'b10;
            seg         <= SEG_DASH;
            sign_led    <= 1'b0;
        end else begin
            state       <= state_n;
            snap        <= snap_n;
            has_snap    <= has_snap | result_valid;
            btn_d       <= next_btn;
            refresh_cnt <= refresh_cnt_n;
            digit_sel   <= digit_sel_n;
            seg         <= glyph_n;
            sign_led    <= sign_n;
        end
    end

    assign page       = page_code(state);
    assign err_active = (state == ST_ERROR);

endmodule

// File: tb/tb_result_display_sequencer.sv
// tb/tb_result_display_sequencer.sv - directed self-checking bench for result_display_sequencer
module tb_result_display_sequencer;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       result_valid = 1'b0;
    logic [3:0] slope_ten = 4'd0, slope_one = 4'd0;
    logic [3:0] b_ten = 4'd0, b_one = 4'd0;
    logic [3:0] det_ten = 4'd0, det_one = 4'd0;
    logic       slope_neg = 1'b0, b_neg = 1'b0, det_neg = 1'b0;
    logic       error_det = 1'b0, error_values = 1'b0;
    logic       next_btn = 1'b0;
    logic [6:0] seg;
    logic [1:0] digit_sel;
    logic       sign_led;
    logic [1:0] page;
    logic       err_active;

    int checks = 0;
    int failures = 0;

    result_display_sequencer #(.REFRESH_DIV(RD)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .slope_ten    (slope_ten),
        .slope_one    (slope_one),
        .b_ten        (b_ten),
        .b_one        (b_one),
        .det_ten      (det_ten),
        .det_one      (det_one),
        .slope_neg    (slope_neg),
        .b_neg        (b_neg),
        .det_neg      (det_neg),
        .error_det    (error_det),
        .error_values (error_values),
        .next_btn     (next_btn),
        .seg          (seg),
        .digit_sel    (digit_sel),
        .sign_led     (sign_led),
        .page         (page),
        .err_active   (err_active)
    );

    always #5 clk = ~clk;

    task automatic wait_sel(input logic [1:0] want, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * RD + 2; i++) begin
            if (digit_sel === want) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int toggles;
        bit seg_bad;
        logic [1:0] prev;
        #12;
        checks++; if (seg !== 7'h40) begin failures++; $display("FAIL reset_seg got=%h exp=40", seg); end
        checks++; if (digit_sel !== 2'b10) begin failures++; $display("FAIL reset_sel got=%b exp=10", digit_sel); end
        checks++; if (page !== 2'd0 || err_active !== 1'b0 || sign_led !== 1'b0) begin
            failures++; $display("FAIL reset_flags page=%0d err=%b sign=%b exp 0/0/0", page, err_active, sign_led);
        end
        @(negedge clk);
        rst = 1'b1;
        toggles = 0;
        seg_bad = 1'b0;
        prev = digit_sel;
        for (int i = 0; i < 3 * RD; i++) begin
            @(negedge clk);
            if (digit_sel !== prev) toggles++;
            prev = digit_sel;
            if (seg !== 7'h40) seg_bad = 1'b1;
        end
        checks++; if (toggles != 3) begin failures++; $display("FAIL wait_toggles got=%0d exp=3", toggles); end
        checks++; if (seg_bad) begin failures++; $display("FAIL wait_dash got=%h exp=40", seg); end
    endtask

    task automatic test_result();
        bit ok;
        @(negedge clk);
        slope_ten = 4'd1; slope_one = 4'd2; slope_neg = 1'b1;
        b_ten = 4'd0; b_one = 4'd7; b_neg = 1'b0;
        det_ten = 4'd0; det_one = 4'd3; det_neg = 1'b1;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        checks++; if (page !== 2'd1) begin failures++; $display("FAIL result_page got=%0d exp=1", page); end
        checks++; if (digit_sel !== 2'b10 || seg !== 7'h06) begin
            failures++; $display("FAIL slope_tens sel=%b seg=%h exp sel=10 seg=06", digit_sel, seg);
        end
        checks++; if (sign_led !== 1'b1) begin failures++; $display("FAIL slope_sign got=%b exp=1", sign_led); end
        wait_sel(2'b01, ok);
        checks++; if (!ok || seg !== 7'h5B || sign_led !== 1'b1) begin
            failures++; $display("FAIL slope_ones ok=%b seg=%h sign=%b exp seg=5B sign=1", ok, seg, sign_led);
        end
    endtask

    task automatic test_paging();
        bit ok;
        next_btn = 1'b1;
        @(negedge clk);
        checks++; if (page !== 2'd2 || digit_sel !== 2'b10 || seg !== 7'h3F || sign_led !== 1'b0) begin
            failures++; $display("FAIL b_tens page=%0d sel=%b seg=%h sign=%b exp 2/10/3F/0", page, digit_sel, seg, sign_led);
        end
        repeat (100) @(negedge clk);
        checks++; if (page !== 2'd2) begin failures++; $display("FAIL btn_hold page=%0d exp=2", page); end
        wait_sel(2'b01, ok);
        checks++; if (!ok || seg !== 7'h07) begin failures++; $display("FAIL b_ones ok=%b seg=%h exp=07", ok, seg); end
        next_btn = 1'b0;
        @(negedge clk);
        next_btn = 1'b1;
        @(negedge clk);
        checks++; if (page !== 2'd3 || seg !== 7'h3F || sign_led !== 1'b1) begin
            failures++; $display("FAIL det_page page=%0d seg=%h sign=%b exp 3/3F/1", page, seg, sign_led);
        end
        next_btn = 1'b0;
        @(negedge clk);
        next_btn = 1'b1;
        @(negedge clk);
        next_btn = 1'b0;
        checks++; if (page !== 2'd1 || seg !== 7'h06) begin
            failures++; $display("FAIL wrap_page page=%0d seg=%h exp 1/06", page, seg);
        end
    endtask

    task automatic test_errors();
        bit ok;
        error_det = 1'b1;
        @(negedge clk);
        checks++; if (page !== 2'd0 || err_active !== 1'b1 || seg !== 7'h79 || sign_led !== 1'b0) begin
            failures++; $display("FAIL err_det_tens page=%0d err=%b seg=%h sign=%b exp 0/1/79/0", page, err_active, seg, sign_led);
        end
        next_btn = 1'b1;
        wait_sel(2'b01, ok);
        checks++; if (!ok || seg !== 7'h06 || page !== 2'd0) begin
            failures++; $display("FAIL err_det_ones ok=%b seg=%h page=%0d exp 06/0", ok, seg, page);
        end
        next_btn = 1'b0;
        error_values = 1'b1;
        @(negedge clk);
        wait_sel(2'b01, ok);
        checks++; if (!ok || seg !== 7'h5B) begin failures++; $display("FAIL err_values_ones ok=%b seg=%h exp=5B", ok, seg); end
        error_det = 1'b0;
        error_values = 1'b0;
        @(negedge clk);
        checks++; if (page !== 2'd1 || err_active !== 1'b0 || digit_sel !== 2'b10 || seg !== 7'h06 || sign_led !== 1'b1) begin
            failures++; $display("FAIL err_exit page=%0d err=%b sel=%b seg=%h sign=%b exp 1/0/10/06/1",
                                 page, err_active, digit_sel, seg, sign_led);
        end
    endtask

    task automatic test_zero_ovf();
        bit ok;
        slope_ten = 4'd0; slope_one = 4'd0; slope_neg = 1'b1;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        checks++; if (page !== 2'd1 || sign_led !== 1'b0 || seg !== 7'h3F) begin
            failures++; $display("FAIL zero_sign page=%0d sign=%b seg=%h exp 1/0/3F", page, sign_led, seg);
        end
        slope_ten = 4'd12; slope_one = 4'd5;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        wait_sel(2'b10, ok);
        checks++; if (!ok || seg !== 7'h5C || sign_led !== 1'b1) begin
            failures++; $display("FAIL ovf_tens ok=%b seg=%h sign=%b exp 5C/1", ok, seg, sign_led);
        end
        @(negedge clk);
        wait_sel(2'b01, ok);
        checks++; if (!ok || seg !== 7'h6D) begin failures++; $display("FAIL ovf_ones ok=%b seg=%h exp=6D", ok, seg); end
    endtask

    task automatic test_refresh_keeps_page();
        bit ok;
        next_btn = 1'b1;
        @(negedge clk);
        next_btn = 1'b0;
        b_ten = 4'd4; b_one = 4'd9; b_neg = 1'b1;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        checks++; if (page !== 2'd2) begin failures++; $display("FAIL refresh_page got=%0d exp=2", page); end
        wait_sel(2'b10, ok);
        checks++; if (!ok || seg !== 7'h66 || sign_led !== 1'b1) begin
            failures++; $display("FAIL refresh_tens ok=%b seg=%h sign=%b exp 66/1", ok, seg, sign_led);
        end
        @(negedge clk);
        wait_sel(2'b01, ok);
        checks++; if (!ok || seg !== 7'h6F) begin failures++; $display("FAIL refresh_ones ok=%b seg=%h exp=6F", ok, seg); end
    endtask

    task automatic test_error_from_wait();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        error_det = 1'b1;
        @(negedge clk);
        checks++; if (page !== 2'd0 || err_active !== 1'b1) begin
            failures++; $display("FAIL wait_err page=%0d err=%b exp 0/1", page, err_active);
        end
        error_det = 1'b0;
        @(negedge clk);
        checks++; if (page !== 2'd0 || err_active !== 1'b0 || seg !== 7'h40) begin
            failures++; $display("FAIL nosnap_exit page=%0d err=%b seg=%h exp 0/0/40", page, err_active, seg);
        end
        slope_ten = 4'd3; slope_one = 4'd8; slope_neg = 1'b0;
        error_values = 1'b1;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        checks++; if (page !== 2'd0 || err_active !== 1'b1 || seg !== 7'h79) begin
            failures++; $display("FAIL simul_err page=%0d err=%b seg=%h exp 0/1/79", page, err_active, seg);
        end
        error_values = 1'b0;
        @(negedge clk);
        checks++; if (page !== 2'd1 || seg !== 7'h4F || sign_led !== 1'b0) begin
            failures++; $display("FAIL simul_snap page=%0d seg=%h sign=%b exp 1/4F/0", page, seg, sign_led);
        end
    endtask

    initial begin
        test_reset();
        test_result();
        test_paging();
        test_errors();
        test_zero_ovf();
        test_refresh_keeps_page();
        test_error_from_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
